omsp_spm_violation_ctrl: RTL and testbench
==========================================

Name: omsp_spm_violation_ctrl

Overview:
- Downstream consumer of the per-SPM violation vector produced by the SPM control/array.
- Latches the first violation's context: PC, memory address, offending SPM index and access kind.
- Raises a registered interrupt request toward the frontend and holds it until acknowledged.
- Keeps the captured record until software clears it; counts all violations and flags any that occur while a record is held.

Parameters:
NB_SPMS, 4, number of SPMs; width of the violation vector
ID_W, 2, width of the SPM index output (ceil(log2(NB_SPMS)), minimum 1)
CNT_W, 8, width of the saturating violation counter

Ports:
mclk  input  1  main clock
puc_rst  input  1  reset, asynchronous, active-high
spms_violation  input  NB_SPMS  per-SPM violation flags, bit 0 = SPM 0
pc  input  16  current program counter
eu_mab  input  16  execution unit memory address bus
eu_mb_en  input  1  execution unit memory bus enable
eu_mb_wr  input  2  execution unit memory bus write strobes
irq_acc  input  1  frontend interrupt accept, 1-cycle pulse
viol_clr  input  1  software clear of record, counter and overflow, 1-cycle pulse
viol_irq  output  1  violation interrupt request
viol_pc  output  16  PC at captured violation
viol_addr  output  16  eu_mab at captured violation
viol_id  output  ID_W  lowest-index SPM flagging the captured violation
viol_kind  output  2  00 none, 01 exec/fetch, 10 read, 11 write
viol_valid  output  1  a record is held
viol_ovf  output  1  sticky: a violation occurred while a record was held
viol_cnt  output  CNT_W  saturating count of violation cycles

Behaviour:
- Reset: state IDLE; all outputs 0. Asynchronous assertion clears state mid-operation, including PENDING; no pending irq survives reset.
- viol_evt = |spms_violation, evaluated each mclk cycle. Each cycle with viol_evt=1 is one violation event.
- Access kind is decoded in the event cycle:
  - write (11) if eu_mb_en & |eu_mb_wr;
  - read (10) if eu_mb_en & ~|eu_mb_wr;
  - otherwise exec (01).
- viol_id is a priority encode of spms_violation: lowest set bit wins.
- FSM states:
  - IDLE: on viol_evt, capture pc, eu_mab, id, kind into the viol_* registers, set viol_valid, go to PENDING. All outputs update on the clock edge ending the event cycle, so viol_irq is 1 from the next cycle.
  - PENDING: viol_irq=1. On irq_acc, go to HELD; viol_irq reads 0 the following cycle.
  - HELD: viol_irq=0; record stable. Only viol_clr leaves this state.
- Violation while PENDING or HELD: record unchanged; viol_ovf set (sticky); counter increments.
- viol_cnt:
  - +1 on every event cycle in any state.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Width is CNT_W; increment is width-truncated and guarded by the saturation check.
- viol_clr is honoured in every state, including PENDING. It returns to IDLE and zeroes the record, viol_valid, viol_ovf, viol_cnt and viol_irq on the next edge.
- viol_clr and viol_evt in the same cycle: clear applies first, then the new event is captured as from IDLE. Result: state PENDING, viol_cnt=1, viol_ovf=0, record holds the new context.
- irq_acc and viol_evt in the same cycle while PENDING: go to HELD; the event counts as overflow.
- irq_acc in IDLE or HELD is ignored.
- Multi-cycle violation (spms_violation high N consecutive cycles from IDLE): first cycle captured; remaining N-1 cycles set viol_ovf; viol_cnt=N.
- Violation behaviour is combinational-input → registered-output only; no combinational path from any input to any output.

Test Plan:
- Reset, then spms_violation=4'b0100, eu_mb_en=1, eu_mb_wr=2'b11, eu_mab=16'h0300, pc=16'hE010 for 1 cycle -> next cycle viol_irq=1, viol_valid=1, viol_id=2, viol_kind=11, viol_addr=16'h0300, viol_pc=16'hE010, viol_cnt=1, viol_ovf=0.
- After the case above, irq_acc pulse -> viol_irq=0 next cycle, record unchanged. Then spms_violation=4'b0001 (read, eu_mab=16'h0400) for 1 cycle -> viol_ovf=1, viol_cnt=2, viol_addr still 16'h0300, viol_irq stays 0.
- spms_violation=4'b1010 with eu_mb_en=0 -> viol_id=1, viol_kind=01. Hold the vector 3 cycles -> viol_cnt=3, viol_ovf=1.
- CNT_W=2: 5 event cycles -> viol_cnt=3 (saturated). viol_clr -> all outputs 0, state IDLE.
- In HELD, viol_clr and a new violation (eu_mab=16'h0500, pc=16'hF000) in the same cycle -> next cycle viol_irq=1, viol_addr=16'h0500, viol_pc=16'hF000, viol_cnt=1, viol_ovf=0.
- Assert puc_rst asynchronously mid-cycle while PENDING -> viol_irq and all outputs go to 0 immediately. After release, irq_acc alone produces no change.

Source files
------------

// File: rtl/omsp_spm_violation_ctrl.sv
// omsp_spm_violation_ctrl
//   Consumes the per-SPM violation vector and keeps a record of the first
//   violation: PC, memory address, lowest flagging SPM index and access kind.
//   While a record is pending it raises viol_irq toward the frontend. The
//   record stays until software clears it. Every violation cycle is counted
//   with saturation. Violations that arrive while a record is held set the
//   sticky overflow flag.
//
// Ports
//   mclk, puc_rst    clock, asynchronous active-high reset
//   spms_violation   per-SPM violation flags, bit 0 = SPM 0
//   pc, eu_mab       context captured on the first violation
//   eu_mb_en/eu_mb_wr  memory bus qualifiers used to decode the access kind
//   irq_acc          frontend accept pulse, moves PENDING to HELD
//   viol_clr         software clear of the record, the counter and the overflow flag
//   viol_*           registered record, interrupt, overflow and counter outputs
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no record held, waiting for a violation
// PENDING | record captured, viol_irq asserted until irq_acc
// HELD    | irq accepted, record frozen until viol_clr
module omsp_spm_violation_ctrl #(
  parameter int NB_SPMS = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic [NB_SPMS-1:0] spms_violation,
  input  logic [15:0]        pc,
  input  logic [15:0]        eu_mab,
  input  logic               eu_mb_en,
  input  logic [1:0]         eu_mb_wr,
  input  logic               irq_acc,
  input  logic               viol_clr,
  output logic               viol_irq,
  output logic [15:0]        viol_pc,
  output logic [15:0]        viol_addr,
  output logic [ID_W-1:0]    viol_id,
  output logic [1:0]         viol_kind,
  output logic               viol_valid,
  output logic               viol_ovf,
  output logic [CNT_W-1:0]   viol_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      addr_q, addr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       kind_q, kind_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             viol_evt;
  logic [ID_W-1:0]  evt_id;
  logic [1:0]       evt_kind;
  state_t           st_eff;
  logic [CNT_W-1:0] cnt_eff;

  assign viol_evt = |spms_violation;

  // Lowest set bit wins: scan downward so the last hit is the lowest index.
  always_comb begin
    evt_id = '0;
    for (int i = NB_SPMS - 1; i >= 0; i--) begin
      if (spms_violation[i]) evt_id = ID_W'(i);
    end
  end

  always_comb begin
    if (eu_mb_en && (|eu_mb_wr)) evt_kind = 2'b11;
    else if (eu_mb_en)           evt_kind = 2'b10;
    else                         evt_kind = 2'b01;
  end

  always_comb begin
    // A clear takes effect first. An event in the same cycle is then
    // handled as if the block were already in IDLE.
    st_eff  = viol_clr ? ST_IDLE : state_q;
    cnt_eff = viol_clr ? '0 : cnt_q;

    state_d = st_eff;
    cnt_d   = cnt_eff;
    pc_d    = viol_clr ? '0 : pc_q;
    addr_d  = viol_clr ? '0 : addr_q;
    id_d    = viol_clr ? '0 : id_q;
    kind_d  = viol_clr ? '0 : kind_q;
    valid_d = viol_clr ? 1'b0 : valid_q;
    ovf_d   = viol_clr ? 1'b0 : ovf_q;

    if (viol_evt && (cnt_eff != CNT_MAX)) cnt_d = cnt_eff + CNT_W'(1);

    case (st_eff)
      ST_IDLE: begin
        if (viol_evt) begin
          pc_d    = pc;
          addr_d  = eu_mab;
          id_d    = evt_id;
          kind_d  = evt_kind;
          valid_d = 1'b1;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (viol_evt) ovf_d = 1'b1;
        if (irq_acc)  state_d = ST_HELD;
      end
      ST_HELD: begin
        if (viol_evt) ovf_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      kind_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // The irq is decoded from the state register alone, so no input can
  // reach it combinationally.
  assign viol_irq   = (state_q == ST_PENDING);
  assign viol_pc    = pc_q;
  assign viol_addr  = addr_q;
  assign viol_id    = id_q;
  assign viol_kind  = kind_q;
  assign viol_valid = valid_q;
  assign viol_ovf   = ovf_q;
  assign viol_cnt   = cnt_q;

endmodule

// File: tb/tb_omsp_spm_violation_ctrl.sv
module tb_omsp_spm_violation_ctrl;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [3:0]  spms_violation;
  logic [15:0] pc, eu_mab;
  logic        eu_mb_en;
  logic [1:0]  eu_mb_wr;
  logic        irq_acc, viol_clr;

  logic        a_irq, a_valid, a_ovf;
  logic [15:0] a_pc, a_addr;
  logic [1:0]  a_id, a_kind;
  logic [7:0]  a_cnt;

  logic        b_irq, b_valid, b_ovf;
  logic [15:0] b_pc, b_addr;
  logic [1:0]  b_id, b_kind;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 mclk = ~mclk;

  omsp_spm_violation_ctrl #(.NB_SPMS(4), .ID_W(2), .CNT_W(8)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .spms_violation(spms_violation),
    .pc(pc), .eu_mab(eu_mab), .eu_mb_en(eu_mb_en), .eu_mb_wr(eu_mb_wr),
    .irq_acc(irq_acc), .viol_clr(viol_clr),
    .viol_irq(a_irq), .viol_pc(a_pc), .viol_addr(a_addr), .viol_id(a_id),
    .viol_kind(a_kind), .viol_valid(a_valid), .viol_ovf(a_ovf), .viol_cnt(a_cnt)
  );

  omsp_spm_violation_ctrl #(.NB_SPMS(4), .ID_W(2), .CNT_W(2)) dut2 (
    .mclk(mclk), .puc_rst(puc_rst), .spms_violation(spms_violation),
    .pc(pc), .eu_mab(eu_mab), .eu_mb_en(eu_mb_en), .eu_mb_wr(eu_mb_wr),
    .irq_acc(irq_acc), .viol_clr(viol_clr),
    .viol_irq(b_irq), .viol_pc(b_pc), .viol_addr(b_addr), .viol_id(b_id),
    .viol_kind(b_kind), .viol_valid(b_valid), .viol_ovf(b_ovf), .viol_cnt(b_cnt)
  );

  // Reference model: a record exists or not, the irq is outstanding or not,
  // and the counter is an unbounded count clipped to each instance width.
  logic        m_valid, m_irq, m_ovf;
  logic [15:0] m_pc, m_addr;
  logic [1:0]  m_id, m_kind;
  int          m_cnt;

  task automatic model_reset();
    m_valid = 0; m_irq = 0; m_ovf = 0;
    m_pc = 0; m_addr = 0; m_id = 0; m_kind = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic old_irq;
    logic evt;
    old_irq = m_irq;
    evt = (spms_violation != 4'b0);
    if (viol_clr) model_reset();
    if (evt) begin
      m_cnt++;
      if (!m_valid) begin
        m_valid = 1; m_irq = 1;
        m_pc = pc; m_addr = eu_mab;
        m_id = 0;
        for (int i = 3; i >= 0; i--) if (spms_violation[i]) m_id = 2'(i);
        m_kind = !eu_mb_en ? 2'd1 : (eu_mb_wr != 2'b00) ? 2'd3 : 2'd2;
      end else begin
        m_ovf = 1;
      end
    end
    if (!viol_clr && irq_acc && old_irq) m_irq = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic irq, input logic valid,
                         input logic [1:0] id, input logic [1:0] kind,
                         input logic [15:0] addr, input logic [15:0] vpc,
                         input int cnt, input logic ovf);
    int c8, c2;
    c8 = (cnt > 255) ? 255 : cnt;
    c2 = (cnt > 3) ? 3 : cnt;
    chk({tag, ".irq"},   32'(a_irq),   32'(irq));
    chk({tag, ".valid"}, 32'(a_valid), 32'(valid));
    chk({tag, ".id"},    32'(a_id),    32'(id));
    chk({tag, ".kind"},  32'(a_kind),  32'(kind));
    chk({tag, ".addr"},  32'(a_addr),  32'(addr));
    chk({tag, ".pc"},    32'(a_pc),    32'(vpc));
    chk({tag, ".cnt8"},  32'(a_cnt),   32'(c8));
    chk({tag, ".ovf"},   32'(a_ovf),   32'(ovf));
    chk({tag, ".w2.irq"},   32'(b_irq),   32'(irq));
    chk({tag, ".w2.valid"}, 32'(b_valid), 32'(valid));
    chk({tag, ".w2.addr"},  32'(b_addr),  32'(addr));
    chk({tag, ".w2.id"},    32'(b_id),    32'(id));
    chk({tag, ".w2.kind"},  32'(b_kind),  32'(kind));
    chk({tag, ".w2.pc"},    32'(b_pc),    32'(vpc));
    chk({tag, ".w2.cnt2"},  32'(b_cnt),   32'(c2));
    chk({tag, ".w2.ovf"},   32'(b_ovf),   32'(ovf));
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, m_irq, m_valid, m_id, m_kind, m_addr, m_pc, m_cnt, m_ovf);
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] p, input logic [15:0] a,
                       input logic en, input logic [1:0] wr, input logic acc, input logic clr);
    spms_violation = v; pc = p; eu_mab = a; eu_mb_en = en; eu_mb_wr = wr;
    irq_acc = acc; viol_clr = clr;
  endtask

  // One clock: inputs already driven, model follows the edge, sample at +1.
  task automatic step();
    @(posedge mclk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] p, a;
    logic        en;
    logic [1:0]  wr;
    logic        acc, clr;
    logic        e_irq, e_valid;
    logic [1:0]  e_id, e_kind;
    logic [15:0] e_addr, e_pc;
    int          e_cnt;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [15:0] p, logic [15:0] a, logic en,
                              logic [1:0] wr, logic acc, logic clr, logic e_irq,
                              logic e_valid, logic [1:0] e_id, logic [1:0] e_kind,
                              logic [15:0] e_addr, logic [15:0] e_pc, int e_cnt, logic e_ovf);
    vec_t r;
    r.v = v; r.p = p; r.a = a; r.en = en; r.wr = wr; r.acc = acc; r.clr = clr;
    r.e_irq = e_irq; r.e_valid = e_valid; r.e_id = e_id; r.e_kind = e_kind;
    r.e_addr = e_addr; r.e_pc = e_pc; r.e_cnt = e_cnt; r.e_ovf = e_ovf;
    return r;
  endfunction

  vec_t tbl[12];

  initial begin
    //           v        pc        mab      en  wr   acc clr  irq val id kind addr      pc       cnt ovf
    tbl[0]  = mk(4'b0100, 16'hE010, 16'h0300, 1, 2'b11, 0, 0,  1,  1,  2, 3, 16'h0300, 16'hE010, 1, 0);
    tbl[1]  = mk(4'b0000, 16'hE012, 16'h0000, 0, 2'b00, 1, 0,  0,  1,  2, 3, 16'h0300, 16'hE010, 1, 0);
    tbl[2]  = mk(4'b0001, 16'hE020, 16'h0400, 1, 2'b00, 0, 0,  0,  1,  2, 3, 16'h0300, 16'hE010, 2, 1);
    tbl[3]  = mk(4'b0000, 16'hE022, 16'h0000, 0, 2'b00, 0, 1,  0,  0,  0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[4]  = mk(4'b1010, 16'hE100, 16'h0600, 0, 2'b10, 0, 0,  1,  1,  1, 1, 16'h0600, 16'hE100, 1, 0);
    tbl[5]  = mk(4'b1010, 16'hE102, 16'h0602, 0, 2'b10, 0, 0,  1,  1,  1, 1, 16'h0600, 16'hE100, 2, 1);
    tbl[6]  = mk(4'b1010, 16'hE104, 16'h0604, 0, 2'b10, 0, 0,  1,  1,  1, 1, 16'h0600, 16'hE100, 3, 1);
    tbl[7]  = mk(4'b0000, 16'hE106, 16'h0000, 0, 2'b00, 1, 0,  0,  1,  1, 1, 16'h0600, 16'hE100, 3, 1);
    tbl[8]  = mk(4'b0001, 16'hF000, 16'h0500, 0, 2'b00, 0, 1,  1,  1,  0, 1, 16'h0500, 16'hF000, 1, 0);
    tbl[9]  = mk(4'b1000, 16'hF002, 16'h0700, 1, 2'b01, 1, 0,  0,  1,  0, 1, 16'h0500, 16'hF000, 2, 1);
    tbl[10] = mk(4'b0000, 16'hF004, 16'h0000, 0, 2'b00, 1, 0,  0,  1,  0, 1, 16'h0500, 16'hF000, 2, 1);
    tbl[11] = mk(4'b0000, 16'hF006, 16'h0000, 0, 2'b00, 0, 1,  0,  0,  0, 0, 16'h0000, 16'h0000, 0, 0);

    puc_rst = 1'b1;
    drive(4'b0, 16'h0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge mclk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    #3 puc_rst = 1'b0;
    @(posedge mclk);
    #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].p, tbl[i].a, tbl[i].en, tbl[i].wr, tbl[i].acc, tbl[i].clr);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].e_irq, tbl[i].e_valid, tbl[i].e_id,
              tbl[i].e_kind, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_ovf);
    end
    drive(4'b0, 16'h0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0);

    // Saturation: five event cycles, narrow instance holds 3
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 16'hC000 + 16'(i), 16'h0800 + 16'(i), 1'b1, 2'b00, 1'b0, 1'b0);
      step();
    end
    chk_out("sat", 1, 1, 1, 2, 16'h0800, 16'hC000, 5, 1);
    drive(4'b0, 16'h0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b1);
    step();
    chk_out("sat_clr", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    // Asynchronous reset in PENDING, away from any clock edge
    drive(4'b0100, 16'hD000, 16'h0900, 1'b1, 2'b01, 1'b0, 1'b0);
    step();
    chk_out("pre_rst", 1, 1, 2, 3, 16'h0900, 16'hD000, 1, 0);
    drive(4'b0, 16'h0, 16'h0, 1'b0, 2'b0, 1'b0, 1'b0);
    #2 puc_rst = 1'b1;
    #1;
    model_reset();
    chk_out("async_rst", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    #2 puc_rst = 1'b0;
    drive(4'b0, 16'h0, 16'h0, 1'b0, 2'b0, 1'b1, 1'b0);
    step();
    chk_out("acc_after_rst", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      drive(v, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
